// File: rtl/mandelbrot_pkg.sv
// mandelbrot_pkg
// Shared definitions for the Mandelbrot escape-time engine:
//   DEF_W / DEF_FRAC / DEF_ITER_W : default component width, fractional bits and
//                                   iteration-count width (Q4.28, 12-bit count)
//   ESCAPE_R2 : 4.0 in the default format, sized W+2 bits (escape-sum width)
//   TWO       : 2.0 in the default format, sized W bits
//   state_t   : engine FSM states
//   is_pow2   : power-of-two test used by the optional period detector
package mandelbrot_pkg;

    localparam int DEF_W      = 32;
    localparam int DEF_FRAC   = 28;
    localparam int DEF_ITER_W = 12;

    localparam logic signed [DEF_W+1:0] ESCAPE_R2 = (DEF_W+2)'(4) << DEF_FRAC;
    localparam logic signed [DEF_W-1:0] TWO       = DEF_W'(2) << DEF_FRAC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for 1, 2, 4, 8, ... ; false for zero.
    function automatic logic is_pow2(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/mandelbrot_fx_mul.sv
// mandelbrot_fx_mul
// Signed fixed-point multiply: full 2W-bit product, arithmetic shift right by
// FRAC (floor), truncated to W bits.
// Ports:
//   a, b : signed W-bit operands, Q(W-FRAC).FRAC
//   p    : signed W-bit product, same format
module mandelbrot_fx_mul #(
    parameter int W    = 32,
    parameter int FRAC = 28
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] p
);

    logic signed [2*W-1:0] full;

    assign full = a * b;
    assign p    = W'(full >>> FRAC);

endmodule

// File: rtl/mandelbrot_iter_engine.sv
// mandelbrot_iter_engine
// Per-pixel Mandelbrot escape-time engine. Accepts c = c_re + j*c_im, iterates
// z <= z^2 + c once per cycle in signed fixed point and returns the iteration
// count at which |z|^2 exceeded 4.0 (or max_iter if it never did, 0 if c lies
// outside the |re|,|im| <= 2.0 box).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : point handshake (in_ready high only when idle)
//   c_re, c_im, max_iter  : point and iteration limit, latched at accept
//   out_valid/out_ready   : result handshake, result held until out_ready
//   iterations            : escape count
//   busy                  : high while iterating or holding a result
// Optional build macro PERIOD_CHECK_EN: adds a z snapshot taken at power-of-two
// iteration counts; an exact repeat of the snapshot proves the orbit is periodic
// and finishes early with iterations = max_iter. Result values are unchanged.
module mandelbrot_iter_engine
    import mandelbrot_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int FRAC   = DEF_FRAC,
    parameter int ITER_W = DEF_ITER_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [W-1:0]      c_re,
    input  logic signed [W-1:0]      c_im,
    input  logic        [ITER_W-1:0] max_iter,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [ITER_W-1:0] iterations,
    output logic                     busy
);

    localparam logic signed [W+1:0] ESC_LIM = (W+2)'(4) << FRAC;
    localparam logic signed [W-1:0] TWO_Q   = W'(2) << FRAC;

    state_t                    state_reg, state_next;
    logic signed [W-1:0]       zr_reg, zr_next;
    logic signed [W-1:0]       zi_reg, zi_next;
    logic signed [W-1:0]       cre_reg, cre_next;
    logic signed [W-1:0]       cim_reg, cim_next;
    logic        [ITER_W-1:0]  max_reg, max_next;
    logic        [ITER_W-1:0]  n_reg, n_next;
    logic        [ITER_W-1:0]  iter_reg, iter_next;
    logic                      oor_reg, oor_next;
`ifdef PERIOD_CHECK_EN
    logic signed [W-1:0]       zs_re_reg, zs_re_next;
    logic signed [W-1:0]       zs_im_reg, zs_im_next;
    logic                      period_hit;
`endif

    // Multipliers: [0] zr*zr, [1] zi*zi, [2] zr*zi
    logic signed [W-1:0] mul_a [3];
    logic signed [W-1:0] mul_b [3];
    logic signed [W-1:0] mul_p [3];

    assign mul_a[0] = zr_reg;
    assign mul_b[0] = zr_reg;
    assign mul_a[1] = zi_reg;
    assign mul_b[1] = zi_reg;
    assign mul_a[2] = zr_reg;
    assign mul_b[2] = zi_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_mul
            mandelbrot_fx_mul #(
                .W    (W),
                .FRAC (FRAC)
            ) u_mul (
                .a (mul_a[gi]),
                .b (mul_b[gi]),
                .p (mul_p[gi])
            );
        end
    endgenerate

    // Escape test. A component beyond +-2.0 already implies |z|^2 > 4 and its
    // W-bit square could wrap, so it is flagged directly; otherwise both squares
    // are at most 4.0 and their sum fits the W+2-bit adder without overflow.
    logic                big_re, big_im;
    logic signed [W+1:0] mag_sum;
    logic                escaped;

    assign big_re  = (zr_reg > TWO_Q) || (zr_reg < -TWO_Q);
    assign big_im  = (zi_reg > TWO_Q) || (zi_reg < -TWO_Q);
    assign mag_sum = {{2{mul_p[0][W-1]}}, mul_p[0]} + {{2{mul_p[1][W-1]}}, mul_p[1]};
    assign escaped = big_re || big_im || (mag_sum > ESC_LIM);

    logic signed [W-1:0] zr_step, zi_step;

    assign zr_step = mul_p[0] - mul_p[1] + cre_reg;
    assign zi_step = (mul_p[2] <<< 1) + cim_reg;

`ifdef PERIOD_CHECK_EN
    assign period_hit = (n_reg > ITER_W'(1)) && !is_pow2(32'(n_reg))
                        && (zr_reg == zs_re_reg) && (zi_reg == zs_im_reg);
`endif

    assign in_ready   = (state_reg == ST_IDLE);
    assign out_valid  = (state_reg == ST_DONE);
    assign busy       = (state_reg != ST_IDLE);
    assign iterations = iter_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            zr_reg    <= '0;
            zi_reg    <= '0;
            cre_reg   <= '0;
            cim_reg   <= '0;
            max_reg   <= '0;
            n_reg     <= '0;
            iter_reg  <= '0;
            oor_reg   <= 1'b0;
`ifdef PERIOD_CHECK_EN
            zs_re_reg <= '0;
            zs_im_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            zr_reg    <= zr_next;
            zi_reg    <= zi_next;
            cre_reg   <= cre_next;
            cim_reg   <= cim_next;
            max_reg   <= max_next;
            n_reg     <= n_next;
            iter_reg  <= iter_next;
            oor_reg   <= oor_next;
`ifdef PERIOD_CHECK_EN
            zs_re_reg <= zs_re_next;
            zs_im_reg <= zs_im_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        zr_next    = zr_reg;
        zi_next    = zi_reg;
        cre_next   = cre_reg;
        cim_next   = cim_reg;
        max_next   = max_reg;
        n_next     = n_reg;
        iter_next  = iter_reg;
        oor_next   = oor_reg;
`ifdef PERIOD_CHECK_EN
        zs_re_next = zs_re_reg;
        zs_im_next = zs_im_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    cre_next   = c_re;
                    cim_next   = c_im;
                    max_next   = max_iter;
                    zr_next    = '0;
                    zi_next    = '0;
                    n_next     = '0;
                    oor_next   = (c_re > TWO_Q) || (c_re < -TWO_Q) ||
                                 (c_im > TWO_Q) || (c_im < -TWO_Q);
`ifdef PERIOD_CHECK_EN
                    zs_re_next = '0;
                    zs_im_next = '0;
`endif
                    state_next = ST_ITER;
                end
            end
            ST_ITER: begin
                if (oor_reg) begin
                    iter_next  = '0;
                    state_next = ST_DONE;
                end else if (escaped) begin
                    iter_next  = n_reg;
                    state_next = ST_DONE;
`ifdef PERIOD_CHECK_EN
                end else if (period_hit) begin
                    iter_next  = max_reg;
                    state_next = ST_DONE;
`endif
                end else if (n_reg == max_reg) begin
                    iter_next  = max_reg;
                    state_next = ST_DONE;
                end else begin
                    zr_next = zr_step;
                    zi_next = zi_step;
                    n_next  = n_reg + ITER_W'(1);
`ifdef PERIOD_CHECK_EN
                    if (is_pow2(32'(n_reg))) begin
                        zs_re_next = zr_step;
                        zs_im_next = zi_step;
                    end
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// tb_mandelbrot_iter_engine
// Directed and randomized points for mandelbrot_iter_engine (Q4.28, 12-bit count).
// Random points are scored against an integer escape-time model; latency is
// checked as the number of clock edges from the accepting edge to out_valid.
module tb_mandelbrot_iter_engine;

    localparam int W      = 32;
    localparam int FRAC   = 28;
    localparam int ITER_W = 12;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [W-1:0]      c_re = '0;
    logic signed [W-1:0]      c_im = '0;
    logic        [ITER_W-1:0] max_iter = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic        [ITER_W-1:0] iterations;
    logic                     busy;

    int total = 0;
    int bad   = 0;

    mandelbrot_iter_engine #(.W(W), .FRAC(FRAC), .ITER_W(ITER_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .c_re       (c_re),
        .c_im       (c_im),
        .max_iter   (max_iter),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .iterations (iterations),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Escape-time reference: exact integer squares (floor of Q.28 products),
    // iterates until |z|^2 > 4.0 or n reaches the limit. k = ITER cycles spent.
    function automatic void ref_model(input int cre, input int cim, input int mx,
                                      output int it, output int k);
        longint zr = 0, zi = 0, sr, si, cr;
        longint two  = longint'(2) <<< FRAC;
        longint four = longint'(4) <<< FRAC;
        it = mx;
        k  = mx + 1;
        if (cre > two || cre < -two || cim > two || cim < -two) begin
            it = 0;
            k  = 1;
            return;
        end
        for (int n = 0; n <= mx; n++) begin
            sr = (zr * zr) >>> FRAC;
            si = (zi * zi) >>> FRAC;
            if (sr + si > four) begin
                it = n;
                k  = n + 1;
                return;
            end
            if (n == mx) begin
                it = mx;
                k  = n + 1;
                return;
            end
            cr = (zr * zi) >>> FRAC;
            zr = longint'(int'(sr - si + cre));
            zi = longint'(int'(2 * cr + cim));
        end
    endfunction

    // Present one point, measure latency, optionally hold off out_ready for
    // hold cycles, then release the result.
    task automatic run_point(input string tag, input int cre, input int cim,
                             input int mx, input int hold,
                             output int it_obs, output int lat);
        int guard;
        it_obs = -1;
        lat    = 0;
        guard  = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_in_ready"}, longint'(in_ready), 1);
        c_re     = cre;
        c_im     = cim;
        max_iter = ITER_W'(mx);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 6000);
        check({tag, "_out_valid"}, longint'(out_valid), 1);
        it_obs = int'(iterations);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check({tag, "_hold_valid"}, longint'(out_valid), 1);
            check({tag, "_hold_iter"}, longint'(iterations), longint'(it_obs));
            check({tag, "_hold_in_ready"}, longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_released"}, longint'({out_valid, in_ready, busy}), 3'b010);
    endtask

    initial begin
        int it, lat, exp_it, exp_k, cre, cim, mx;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", longint'({in_ready, out_valid, busy}), 3'b100);
        check("reset_iterations", longint'(iterations), 0);
        rst = 1'b0;

        // c = (1.0, 0), max 255 -> 3 after 4 ITER cycles
        run_point("c_1_0", 32'h1000_0000, 0, 255, 0, it, lat);
        $display("point c_1_0 iterations=%0d latency=%0d", it, lat);
        check("c_1_0_iter", it, 3);
        check("c_1_0_lat", lat, 4);

        // c = (0, 0), max 255 -> never escapes
        run_point("c_0_0", 0, 0, 255, 0, it, lat);
        $display("point c_0_0 iterations=%0d latency=%0d", it, lat);
        check("c_0_0_iter", it, 255);
        check("c_0_0_lat", lat, 256);

        // c = (-2.0, 0): |z|^2 sits exactly at 4.0, not an escape
        run_point("c_m2_0", 32'hE000_0000, 0, 100, 0, it, lat);
        $display("point c_m2_0 iterations=%0d latency=%0d", it, lat);
        check("c_m2_0_iter", it, 100);
        check("c_m2_0_lat", lat, 101);

        // c = (0, 1.0): period-2 orbit
        run_point("c_0_1", 0, 32'h1000_0000, 255, 0, it, lat);
        $display("point c_0_1 iterations=%0d latency=%0d", it, lat);
        check("c_0_1_iter", it, 255);
`ifdef PERIOD_CHECK_EN
        check("c_0_1_lat_short", longint'(lat <= 5), 1);
`else
        check("c_0_1_lat", lat, 256);
`endif

        // Out-of-range c -> 0 after one ITER cycle
        run_point("c_3_0", 32'h3000_0000, 0, 255, 0, it, lat);
        $display("point c_3_0 iterations=%0d latency=%0d", it, lat);
        check("c_3_0_iter", it, 0);
        check("c_3_0_lat", lat, 1);

        // max_iter = 0
        run_point("max0", 0, 0, 0, 0, it, lat);
        $display("point max0 iterations=%0d latency=%0d", it, lat);
        check("max0_iter", it, 0);
        check("max0_lat", lat, 1);

        // Backpressure: result held 10 cycles, input offered but refused
        run_point("bp", 32'h1000_0000, 0, 255, 10, it, lat);
        $display("point bp iterations=%0d latency=%0d", it, lat);
        check("bp_iter", it, 3);

        // Reset mid-iteration
        @(negedge clk);
        c_re = 0; c_im = 0; max_iter = 12'd255; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("mid_busy", longint'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        $display("reset mid-iteration in_ready=%0d out_valid=%0d busy=%0d", in_ready, out_valid, busy);
        check("mid_rst_outputs", longint'({in_ready, out_valid, busy}), 3'b100);
        rst = 1'b0;

        // Randomized points against the reference model
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 1) == 1)
                cre = int'($urandom_range(0, 32'd1342177280)) - 671088640;
            else
                cre = int'($urandom_range(0, 32'd536870912)) - 268435456;
            cim = int'($urandom_range(0, 32'd1342177280)) - 671088640;
            if ($urandom_range(0, 3) == 0)
                cim = int'($urandom_range(0, 32'd268435456)) - 134217728;
            mx = int'($urandom_range(0, 60));
            ref_model(cre, cim, mx, exp_it, exp_k);
            run_point("rand", cre, cim, mx, 0, it, lat);
            $display("rand %0d c=(%0d,%0d) max=%0d iterations=%0d expected=%0d latency=%0d",
                     r, cre, cim, mx, it, exp_it, lat);
            check("rand_iter", it, exp_it);
`ifndef PERIOD_CHECK_EN
            check("rand_lat", lat, exp_k);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
